// File: rtl/lc3b_types.sv
// Shared LC-3b types used by the memory arbiter: the cache line type,
// the arbiter state encoding and the round-robin pick helper.
package lc3b_types;

    typedef logic [127:0] lc3b_line;

    localparam logic [1:0] ARB_IDLE    = 2'd0;
    localparam logic [1:0] ARB_GRANT_I = 2'd1;
    localparam logic [1:0] ARB_GRANT_D = 2'd2;

    typedef enum logic [1:0] {
        IDLE    = ARB_IDLE,
        GRANT_I = ARB_GRANT_I,
        GRANT_D = ARB_GRANT_D
    } lc3b_arb_state;

    // On a tie the side that did not finish last wins; last_d=1 favours I.
    function automatic lc3b_arb_state arb_pick(input logic i_req,
                                               input logic d_req,
                                               input logic last_d);
        lc3b_arb_state pick;
        pick = IDLE;
        if (i_req && d_req) begin
            pick = last_d ? GRANT_I : GRANT_D;
        end else if (i_req) begin
            pick = GRANT_I;
        end else if (d_req) begin
            pick = GRANT_D;
        end
        return pick;
    endfunction

endpackage

// File: rtl/mem_arbiter_ctrl.sv
// Grant FSM for the shared memory port: arbitrates in IDLE, holds a grant
// until completion or abandon, and remembers which side finished last.
module mem_arbiter_ctrl
    import lc3b_types::*;
(
    input  logic          clk,
    input  logic          reset,
    input  logic          i_req,
    input  logic          d_req,
    input  logic          pmem_resp,
    output logic          grant_i,
    output logic          grant_d,
    output lc3b_arb_state state
);

    lc3b_arb_state state_q, state_d;
    logic          last_d_q, last_d_d;

    always_comb begin
        state_d  = state_q;
        last_d_d = last_d_q;
        case (state_q)
            IDLE: begin
                // pmem_resp is deliberately ignored here.
                state_d = arb_pick(i_req, d_req, last_d_q);
            end
            GRANT_I: begin
                if (pmem_resp) begin
                    state_d  = IDLE;
                    last_d_d = 1'b0;
                end else if (!i_req) begin
                    // Abandoned grant: fairness history stays as it was.
                    state_d = IDLE;
                end
            end
            GRANT_D: begin
                if (pmem_resp) begin
                    state_d  = IDLE;
                    last_d_d = 1'b1;
                end else if (!d_req) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            last_d_q <= 1'b1;
        end else begin
            state_q  <= state_d;
            last_d_q <= last_d_d;
        end
    end

    assign grant_i = (state_q == GRANT_I);
    assign grant_d = (state_q == GRANT_D);
    assign state   = state_q;

endmodule

// File: rtl/mem_arbiter.sv
// Shares one physical-memory port between the I-cache and D-cache miss paths.
// Strobes depend only on registered grant state, never on pmem_resp.
module mem_arbiter
    import lc3b_types::*;
#(
    parameter int ADDR_WIDTH = 16,
    parameter int LINE_WIDTH = 128
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_read,
    input  logic [ADDR_WIDTH-1:0] i_address,
    output logic                  i_resp,
    output logic [LINE_WIDTH-1:0] i_rdata,
    input  logic                  d_read,
    input  logic                  d_write,
    input  logic [ADDR_WIDTH-1:0] d_address,
    input  logic [LINE_WIDTH-1:0] d_wdata,
    output logic                  d_resp,
    output logic [LINE_WIDTH-1:0] d_rdata,
    output logic                  pmem_read,
    output logic                  pmem_write,
    output logic [ADDR_WIDTH-1:0] pmem_address,
    output logic [LINE_WIDTH-1:0] pmem_wdata,
    input  logic [LINE_WIDTH-1:0] pmem_rdata,
    input  logic                  pmem_resp
);

    logic          grant_i;
    logic          grant_d;
    lc3b_arb_state arb_state;

    mem_arbiter_ctrl u_ctrl (
        .clk       (clk),
        .reset     (reset),
        .i_req     (i_read),
        .d_req     (d_read | d_write),
        .pmem_resp (pmem_resp),
        .grant_i   (grant_i),
        .grant_d   (grant_d),
        .state     (arb_state)
    );

    always_comb begin
        pmem_read    = 1'b0;
        pmem_write   = 1'b0;
        pmem_address = '0;
        pmem_wdata   = '0;
        case (arb_state)
            GRANT_I: begin
                pmem_read    = i_read;
                pmem_address = i_address;
            end
            GRANT_D: begin
                // A simultaneous read+write is illegal; the write wins.
                pmem_read    = d_read & ~d_write;
                pmem_write   = d_write;
                pmem_address = d_address;
                pmem_wdata   = d_wdata;
            end
            default: begin
            end
        endcase
    end

    assign i_resp  = grant_i & pmem_resp;
    assign d_resp  = grant_d & pmem_resp;
    assign i_rdata = pmem_rdata;
    assign d_rdata = pmem_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: single transactions, round-robin order,
// IDLE resp immunity, reset mid-grant and requester abandon.
module tb_mem_arbiter;
    import lc3b_types::*;

    localparam int AW = 16;
    localparam int LW = 128;

    logic          clk = 1'b0;
    logic          reset;
    logic          i_read;
    logic [AW-1:0] i_address;
    logic          i_resp;
    lc3b_line      i_rdata;
    logic          d_read;
    logic          d_write;
    logic [AW-1:0] d_address;
    lc3b_line      d_wdata;
    logic          d_resp;
    lc3b_line      d_rdata;
    logic          pmem_read;
    logic          pmem_write;
    logic [AW-1:0] pmem_address;
    lc3b_line      pmem_wdata;
    lc3b_line      pmem_rdata;
    logic          pmem_resp;

    int vec_cnt = 0;
    int err_cnt = 0;

    localparam logic [AW-1:0] I_ADDR = 16'h0100;
    localparam logic [AW-1:0] D_ADDR = 16'h0200;
    localparam lc3b_line LINE_A5 = {16{8'hA5}};
    localparam lc3b_line LINE_DEAD = {8{16'hDEAD}};
    localparam lc3b_line LINE_5A = {16{8'h5A}};

    mem_arbiter #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW)) dut (
        .clk          (clk),
        .reset        (reset),
        .i_read       (i_read),
        .i_address    (i_address),
        .i_resp       (i_resp),
        .i_rdata      (i_rdata),
        .d_read       (d_read),
        .d_write      (d_write),
        .d_address    (d_address),
        .d_wdata      (d_wdata),
        .d_resp       (d_resp),
        .d_rdata      (d_rdata),
        .pmem_read    (pmem_read),
        .pmem_write   (pmem_write),
        .pmem_address (pmem_address),
        .pmem_wdata   (pmem_wdata),
        .pmem_rdata   (pmem_rdata),
        .pmem_resp    (pmem_resp)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic wait_strobe(output int n);
        n = 0;
        while (!(pmem_read || pmem_write) && n < 20) begin
            step();
            settle();
            n++;
        end
    endtask

    // Strobe one cycle after IDLE, resp three cycles after the strobe,
    // then one cycle back in IDLE with resp low.
    task automatic run_txn(input logic [AW-1:0] exp_addr, input logic exp_d, input string tag);
        int n;
        wait_strobe(n);
        check({tag, " latency"}, 128'(n), 128'(1));
        check({tag, " addr"}, 128'(pmem_address), 128'(exp_addr));
        repeat (3) step();
        pmem_resp  = 1'b1;
        pmem_rdata = LINE_5A;
        settle();
        check({tag, " i_resp"}, 128'(i_resp), 128'(!exp_d));
        check({tag, " d_resp"}, 128'(d_resp), 128'(exp_d));
        step();
        pmem_resp = 1'b0;
        settle();
    endtask

    initial begin
        reset      = 1'b1;
        i_read     = 1'b0;
        i_address  = '0;
        d_read     = 1'b0;
        d_write    = 1'b0;
        d_address  = '0;
        d_wdata    = '0;
        pmem_rdata = '0;
        pmem_resp  = 1'b0;
        step();
        step();
        check("rst pmem_read", 128'(pmem_read), 128'(0));
        check("rst pmem_write", 128'(pmem_write), 128'(0));
        check("rst pmem_address", 128'(pmem_address), 128'(0));
        check("rst i_resp", 128'(i_resp), 128'(0));
        check("rst d_resp", 128'(d_resp), 128'(0));
        check("rst state", 128'(dut.arb_state), 128'(IDLE));

        // Single I read.
        reset     = 1'b0;
        i_read    = 1'b1;
        i_address = 16'h0040;
        settle();
        check("i idle no strobe", 128'(pmem_read), 128'(0));
        step();
        settle();
        check("i pmem_read", 128'(pmem_read), 128'(1));
        check("i pmem_address", 128'(pmem_address), 128'(16'h0040));
        check("i pmem_write", 128'(pmem_write), 128'(0));
        pmem_resp  = 1'b1;
        pmem_rdata = LINE_A5;
        settle();
        check("i i_resp", 128'(i_resp), 128'(1));
        check("i i_rdata", i_rdata, LINE_A5);
        check("i d_resp", 128'(d_resp), 128'(0));
        step();
        pmem_resp = 1'b0;
        i_read    = 1'b0;
        settle();
        check("i back idle", 128'(dut.arb_state), 128'(IDLE));
        check("i strobe gone", 128'(pmem_read), 128'(0));

        // Single D write-back.
        d_write   = 1'b1;
        d_address = 16'h1230;
        d_wdata   = LINE_DEAD;
        step();
        settle();
        check("d pmem_write", 128'(pmem_write), 128'(1));
        check("d pmem_read", 128'(pmem_read), 128'(0));
        check("d pmem_address", 128'(pmem_address), 128'(16'h1230));
        check("d pmem_wdata", pmem_wdata, LINE_DEAD);
        pmem_resp = 1'b1;
        settle();
        check("d d_resp", 128'(d_resp), 128'(1));
        check("d i_resp", 128'(i_resp), 128'(0));
        step();
        pmem_resp = 1'b0;
        d_write   = 1'b0;
        settle();

        // Both requesting from reset: I, D, I, D with one idle cycle between.
        reset     = 1'b1;
        i_read    = 1'b1;
        i_address = I_ADDR;
        d_read    = 1'b1;
        d_address = D_ADDR;
        step();
        reset = 1'b0;
        settle();
        check("rr start idle", 128'(dut.arb_state), 128'(IDLE));
        run_txn(I_ADDR, 1'b0, "rr0 I");
        run_txn(D_ADDR, 1'b1, "rr1 D");
        run_txn(I_ADDR, 1'b0, "rr2 I");
        run_txn(D_ADDR, 1'b1, "rr3 D");

        // pmem_resp while idle must not leak to either side.
        i_read = 1'b0;
        d_read = 1'b0;
        step();
        pmem_resp = 1'b1;
        settle();
        check("idle resp i_resp", 128'(i_resp), 128'(0));
        check("idle resp d_resp", 128'(d_resp), 128'(0));
        step();
        pmem_resp = 1'b0;
        settle();
        check("idle resp state", 128'(dut.arb_state), 128'(IDLE));

        // Reset two cycles into GRANT_D drops the transaction.
        d_read = 1'b1;
        step();
        step();
        settle();
        check("gd pmem_read", 128'(pmem_read), 128'(1));
        reset     = 1'b1;
        pmem_resp = 1'b1;
        settle();
        check("rst mid pmem_read", 128'(pmem_read), 128'(0));
        check("rst mid pmem_address", 128'(pmem_address), 128'(0));
        check("rst mid d_resp", 128'(d_resp), 128'(0));
        check("rst mid state", 128'(dut.arb_state), 128'(IDLE));
        step();
        pmem_resp = 1'b0;
        i_read    = 1'b1;
        reset     = 1'b0;
        settle();
        run_txn(I_ADDR, 1'b0, "post rst I");

        // D abandons mid-grant while I is pending.
        i_read = 1'b0;
        step();
        settle();
        check("ab grant d", 128'(pmem_read), 128'(1));
        check("ab grant d addr", 128'(pmem_address), 128'(D_ADDR));
        i_read = 1'b1;
        step();
        d_read = 1'b0;
        settle();
        check("ab strobe falls", 128'(pmem_read), 128'(0));
        check("ab no d_resp", 128'(d_resp), 128'(0));
        step();
        settle();
        check("ab idle", 128'(dut.arb_state), 128'(IDLE));
        check("ab idle no strobe", 128'(pmem_read), 128'(0));
        step();
        settle();
        check("ab grant i", 128'(pmem_read), 128'(1));
        check("ab grant i addr", 128'(pmem_address), 128'(I_ADDR));
        pmem_resp = 1'b1;
        settle();
        check("ab i_resp", 128'(i_resp), 128'(1));
        step();
        pmem_resp = 1'b0;
        i_read    = 1'b0;
        settle();

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
